// File: rtl/moore_param_pkg.sv
// Shared state encoding for the moore_param channel FSMs.
package moore_param_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HOLD = 2'd2,
    FIRE = 2'd3
  } ch_state_e;

endpackage

// File: rtl/moore_param_ch.sv
// One channel: Moore FSM with hold qualification counter and saturating fire-event counter.
module moore_param_ch
  import moore_param_pkg::*;
#(
  parameter int unsigned SW_W     = 2,
  parameter int unsigned THRESH   = 2,
  parameter int unsigned HOLD_CYC = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SW_W-1:0]  sw,
  input  logic             ctrl,
  input  logic             load,
  input  logic [1:0]       state_in,
  input  logic             clr_cnt,
  output logic [1:0]       state,
  output logic             out,
  output logic [CNT_W-1:0] fire_cnt
);

  localparam int unsigned HcW = $clog2(HOLD_CYC + 1);
  localparam logic [HcW-1:0]   HcLast = HcW'(HOLD_CYC - 1);
  localparam logic [SW_W-1:0]  Thr    = SW_W'(THRESH);
  localparam logic [CNT_W-1:0] CntMax = '1;

  ch_state_e        state_q, state_d;
  logic [HcW-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (load) begin
      state_d = ch_state_e'(state_in);
      hold_d  = '0;
    end else if (ctrl) begin
      unique case (state_q)
        IDLE: if (sw != '0) state_d = ARM;
        ARM: begin
          if (sw == '0) begin
            state_d = IDLE;
          end else if (sw >= Thr) begin
            state_d = HOLD;
            hold_d  = '0;
          end
        end
        HOLD: begin
          if (sw < Thr) begin
            state_d = ARM;
          end else if (hold_q == HcLast) begin
            state_d = FIRE;
          end else begin
            hold_d = hold_q + HcW'(1);
          end
        end
        FIRE: if (sw == '0) state_d = IDLE;
      endcase
    end
  end

  // Count entries into FIRE only; a reload of FIRE while already firing is not an entry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (state_d == FIRE && state_q != FIRE && cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state    = state_q;
  assign out      = (state_q == FIRE);
  assign fire_cnt = cnt_q;

endmodule

// File: rtl/moore_param.sv
// Array of N_CH independent switch-qualification Moore channels.
module moore_param
  import moore_param_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned SW_W     = 2,
  parameter int unsigned THRESH   = 2,
  parameter int unsigned HOLD_CYC = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH*SW_W-1:0]  sw_in,
  input  logic [N_CH-1:0]       ctrl_in,
  input  logic [N_CH-1:0]       load,
  input  logic [1:0]            state_in,
  input  logic                  clr_cnt,
  output logic [2*N_CH-1:0]     state,
  output logic [N_CH-1:0]       out,
  output logic [N_CH*CNT_W-1:0] fire_cnt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    moore_param_ch #(
      .SW_W    (SW_W),
      .THRESH  (THRESH),
      .HOLD_CYC(HOLD_CYC),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .sw      (sw_in[i*SW_W +: SW_W]),
      .ctrl    (ctrl_in[i]),
      .load    (load[i]),
      .state_in(state_in),
      .clr_cnt (clr_cnt),
      .state   (state[2*i +: 2]),
      .out     (out[i]),
      .fire_cnt(fire_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule
